seq_add_sub: RTL
================

Name: seq_add_sub

Overview:
Parametrised, multi-cycle adder/subtractor. It processes a WIDTH-bit operand pair CHUNK bits per clock through an internal CHUNK-bit ripple-carry slice. Operands enter and results leave through valid/ready handshakes. Each result carries carry/borrow, signed-overflow and zero flags. It is the next generation of the team's 4-bit ripple adder/subtractor: same A, B and ctrl semantics, generalised width, area/latency trade-off set by CHUNK.

Parameters:
WIDTH, 8, operand and result width in bits; must be ≥ 2.
CHUNK, 2, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH, and WIDTH % CHUNK == 0. Any other value fails elaboration.
(Derived) NCHUNK = WIDTH/CHUNK, number of compute cycles.

Ports:
clk  input  1  rising-edge clock, single clock domain
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept an operand pair
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ctrl  input  1  0 = A+B, 1 = A−B (two's complement)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
s  output  WIDTH  sum/difference, modulo 2^WIDTH
cout  output  1  final carry out; for subtract, 1 = no borrow (A ≥ B unsigned)
ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
zero  output  1  s == 0

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; in_ready = 1; out_valid = 0; s, cout, ovf, zero = 0; internal registers cleared. Reset mid-operation aborts the operation; no partial result is ever presented.
- FSM states:
  - IDLE: in_ready = 1, out_valid = 0.
    - On in_valid & in_ready at a clock edge: latch a into opA and (b XOR {WIDTH{ctrl}}) into opB; set carry = ctrl, cnt = 0; go to CALC.
  - CALC: in_ready = 0, out_valid = 0.
    - Each cycle: the low CHUNK bits of opA and opB plus carry pass through the ripple slice.
    - The CHUNK sum bits are shifted into the top of the result register, which shifts right by CHUNK. opA and opB also shift right by CHUNK. carry takes the slice carry out. cnt increments.
    - On the final chunk (cnt == NCHUNK−1): capture the carry into the MSB position for ovf; go to DONE.
  - DONE: out_valid = 1; s, cout, ovf and zero are registered and stay stable.
    - On out_valid & out_ready: go to IDLE. in_ready is 0 in DONE.
- ctrl, a and b are sampled only at the acceptance edge. Later changes have no effect on the operation in flight.
- Latency: out_valid rises exactly NCHUNK cycles after the acceptance edge. Minimum initiation interval is NCHUNK+2 cycles (accept, NCHUNK compute edges, handoff edge, return through IDLE).
- CHUNK == WIDTH: NCHUNK = 1, so out_valid is high one cycle after acceptance.
- Backpressure: while out_ready is low in DONE, all outputs hold and in_ready stays 0. Held in_valid is not lost; it is accepted after the return to IDLE.
- in_valid while in_ready = 0 is ignored.
- Outputs change only in the cycle DONE is entered; they keep their last values in IDLE. Consumers qualify them with out_valid.

Test Plan:
(WIDTH = 8, CHUNK = 2 unless noted; out_ready = 1 unless noted.)
1. Additions:
   - a = 0x01, b = 0x00, ctrl = 0 → s = 0x01, cout = 0, ovf = 0, zero = 0; out_valid exactly 4 cycles after acceptance.
   - 0x7F + 0x01 → s = 0x80, cout = 0, ovf = 1.
   - 0xFF + 0x01 → s = 0x00, cout = 1, ovf = 0, zero = 1.
2. Subtractions:
   - 0x05 − 0x03 → s = 0x02, cout = 1, ovf = 0.
   - 0x03 − 0x05 → s = 0xFE, cout = 0, ovf = 0.
   - 0x80 − 0x01 → s = 0x7F, cout = 1, ovf = 1.
   - 0x0B − 0x06 → s = 0x05, cout = 1.
3. Handshake: hold out_ready low 3 cycles in DONE → s and flags stable, in_ready = 0; a second in_valid pulse in CALC is ignored. Release out_ready → IDLE next cycle, in_ready = 1.
4. Reset mid-op: assert rst_n low during the 2nd CALC cycle → out_valid = 0, s = 0, in_ready = 1 immediately. The next op, 0x10 + 0x20, gives s = 0x30.
5. Operand change: change a, b and ctrl during CALC → the result matches the values sampled at acceptance.
6. Parameter sweep:
   - Re-run 1–2 with CHUNK = 1 (latency 8), CHUNK = 8 (latency 1) and WIDTH = 4, CHUNK = 4 (0xB + 0x6 → s = 0x1, cout = 1).
   - Random 1000-op regression against a behavioural reference, checking s, cout, ovf and zero.

Source files
------------

// File: rtl/seq_add_sub.sv
// seq_add_sub: multi-cycle adder/subtractor.
// A WIDTH-bit operand pair is processed CHUNK bits per clock through a
// CHUNK-bit ripple-carry slice. Operands and results use valid/ready
// handshakes; each result carries carry/borrow, signed-overflow and zero flags.
module seq_add_sub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    // Reject illegal parameter combinations at elaboration.
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("seq_add_sub: illegal WIDTH/CHUNK combination");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  opa;
    logic [WIDTH-1:0]  opb;
    logic [WIDTH-1:0]  res;
    logic              carry;
    logic [CW-1:0]     cnt;

    logic [CHUNK-1:0]  ssum;
    logic              scarry;
    logic              smsb_cin;
    logic              rip;
    logic [WIDTH-1:0]  res_next;

    // Ripple slice over the low CHUNK bits of the operand registers; also
    // exposes the carry into the slice's top bit for the overflow flag.
    always_comb begin
        rip      = carry;
        ssum     = '0;
        smsb_cin = 1'b0;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            ssum[i] = opa[i] ^ opb[i] ^ rip;
            if (i == CHUNK - 1) smsb_cin = rip;
            rip = (opa[i] & opb[i]) | (rip & (opa[i] ^ opb[i]));
        end
        scarry = rip;
    end

    // Result register shifts right by CHUNK with the new sum bits entering at the top.
    always_comb begin
        res_next = res >> CHUNK;
        res_next[WIDTH-1 -: CHUNK] = ssum;
    end

    // Control FSM with datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            s         <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        opa      <= a;
                        opb      <= b ^ {WIDTH{ctrl}};
                        carry    <= ctrl;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    opa   <= opa >> CHUNK;
                    opb   <= opb >> CHUNK;
                    res   <= res_next;
                    carry <= scarry;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        s         <= res_next;
                        cout      <= scarry;
                        ovf       <= smsb_cin ^ scarry;
                        zero      <= (res_next == '0);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
